// File: rtl/keypad_scanner_pkg.sv
// Shared constants and state encoding for the 4x4 matrix keypad scanner.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_COLS-1:0] COL_IDLE_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; resets to all-ones (idle pull-up level).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotates one low column, debounces press/release,
// and reports the accepted key as row/col indices with a one-cycle key_valid strobe.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_drive,
  output logic [1:0]          row,
  output logic [1:0]          col,
  output logic                key_valid,
  output logic                key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [NUM_ROWS-1:0] rs;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    count_q, count_d;
  state_t              state_q, state_d;
  logic [NUM_COLS-1:0] col_drive_q, col_drive_d;
  logic [1:0]          cand_row_q, cand_row_d;
  logic [1:0]          cand_col_q, cand_col_d;
  logic [1:0]          row_q, row_d;
  logic [1:0]          col_q, col_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;

  logic                tick;
  logic                hit;
  logic [1:0]          hit_row;
  logic [1:0]          cur_col;
  logic [NUM_COLS-1:0] col_rot;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (rs)
  );

  assign tick    = (div_q == DIV_LAST);
  assign div_d   = tick ? '0 : div_q + 1'b1;
  assign hit     = ~&rs;
  assign col_rot = {col_drive_q[NUM_COLS-2:0], col_drive_q[NUM_COLS-1]};

  // Lowest low row wins when several rows are pressed in the same column.
  always_comb begin
    hit_row = '0;
    cur_col = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) hit_row = 2'(i);
    end
    for (int j = NUM_COLS - 1; j >= 0; j--) begin
      if (!col_drive_q[j]) cur_col = 2'(j);
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    col_drive_d = col_drive_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    row_d       = row_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            cand_row_d = hit_row;
            cand_col_d = cur_col;
            count_d    = CNT_W'(1);
            state_d    = DEBOUNCE;
          end else begin
            col_drive_d = col_rot;
          end
        end
        DEBOUNCE: begin
          if (hit && (hit_row == cand_row_q)) begin
            if (count_q >= CNT_ACCEPT) begin
              row_d       = cand_row_q;
              col_d       = cand_col_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              count_d     = '0;
              state_d     = HELD;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            count_d     = '0;
            col_drive_d = col_rot;
            state_d     = SCAN;
          end
        end
        // The column stays parked while held, so other keys in it are ignored.
        HELD: begin
          if (!hit) begin
            count_d = CNT_W'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (hit) begin
            count_d = '0;
            state_d = HELD;
          end else if (count_q >= CNT_ACCEPT) begin
            key_held_d  = 1'b0;
            count_d     = '0;
            col_drive_d = col_rot;
            state_d     = SCAN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      count_q     <= '0;
      state_q     <= SCAN;
      col_drive_q <= COL_IDLE_RESET;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      count_q     <= count_d;
      state_q     <= state_d;
      col_drive_q <= col_drive_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      row_q       <= row_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_drive = col_drive_q;
  assign row       = row_q;
  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random key traffic,
// compared every cycle against a behavioural keypad-scanning model.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DC  = 3;
  localparam int LAT = 2 + 4 * SD + DC * SD + 1;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  localparam int M_REL  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [1:0] row;
  logic [1:0] col;
  logic       key_valid;
  logic       key_held;

  bit         pressed [4][4];

  int         n_pass  = 0;
  int         n_fail  = 0;
  int         n_total = 0;
  int         n_pulse = 0;
  logic [1:0] last_row = 2'd0;
  logic [1:0] last_col = 2'd0;

  int         m_cyc, m_col, m_mode, m_run, m_crow, m_ccol;
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_row, m_colo;
  bit         m_valid, m_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_COUNT(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_drive (col_drive),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && (col_drive[c] == 1'b0)) row_in[r] = 1'b0;
      end
    end
  end

  // Reference model: one sample of the synchronised rows per dwell, counted agreeing samples.
  always @(posedge clk or posedge reset) begin : model
    int         low, mc, mode, run, crow, ccol;
    logic [1:0] orow, ocol;
    bit         held, valid;
    if (reset) begin
      m_cyc <= 0; m_s1 <= 4'hF; m_s2 <= 4'hF; m_col <= 0; m_mode <= M_SCAN;
      m_run <= 0; m_crow <= 0; m_ccol <= 0; m_row <= 2'd0; m_colo <= 2'd0;
      m_valid <= 1'b0; m_held <= 1'b0;
    end else begin
      low = -1;
      for (int r = 3; r >= 0; r--) if (m_s2[r] == 1'b0) low = r;
      mc = m_col; mode = m_mode; run = m_run; crow = m_crow; ccol = m_ccol;
      orow = m_row; ocol = m_colo; held = m_held; valid = 1'b0;
      if ((m_cyc % SD) == SD - 1) begin
        case (mode)
          M_SCAN: begin
            if (low >= 0) begin crow = low; ccol = mc; run = 1; mode = M_DEB; end
            else mc = (mc + 1) % 4;
          end
          M_DEB: begin
            if (low == crow) begin
              run = run + 1;
              if (run >= DC) begin
                orow = 2'(crow); ocol = 2'(ccol); valid = 1'b1; held = 1'b1;
                run = 0; mode = M_HELD;
              end
            end else begin
              run = 0; mc = (mc + 1) % 4; mode = M_SCAN;
            end
          end
          M_HELD: begin
            if (low < 0) begin run = 1; mode = M_REL; end
          end
          default: begin
            if (low >= 0) begin run = 0; mode = M_HELD; end
            else begin
              run = run + 1;
              if (run >= DC) begin held = 1'b0; run = 0; mc = (mc + 1) % 4; mode = M_SCAN; end
            end
          end
        endcase
      end
      m_cyc <= m_cyc + 1; m_s2 <= m_s1; m_s1 <= row_in;
      m_col <= mc; m_mode <= mode; m_run <= run; m_crow <= crow; m_ccol <= ccol;
      m_row <= orow; m_colo <= ocol; m_held <= held; m_valid <= valid;
    end
  end

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_against_model();
    logic [3:0] one;
    logic [3:0] exp_cd;
    one    = 4'b0001;
    exp_cd = ~(one << m_col);
    check_output("col_drive", col_drive, exp_cd);
    check_output("row", {2'b00, row}, {2'b00, m_row});
    check_output("col", {2'b00, col}, {2'b00, m_colo});
    check_output("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
    check_output("key_held", {3'b000, key_held}, {3'b000, m_held});
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_against_model();
      if (key_valid === 1'b1) begin
        n_pulse++;
        last_row = row;
        last_col = col;
      end
    end
  endtask

  task automatic apply_stimulus(input int r, input int c, input bit v);
    pressed[r][c] = v;
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int limit);
    int start;
    int k;
    start = n_pulse;
    k = 0;
    while ((n_pulse == start) && (k < limit)) begin
      run_cycles(1);
      k++;
    end
    check_output(tag, 4'(n_pulse - start), 4'd1);
  endtask

  task automatic wait_release(input string tag, input int limit);
    int k;
    k = 0;
    while ((key_held === 1'b1) && (k < limit)) begin
      run_cycles(1);
      k++;
    end
    check_output(tag, {3'b000, key_held}, 4'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_col_drive"}, col_drive, 4'b1110);
    check_output({tag, "_row"}, {2'b00, row}, 4'd0);
    check_output({tag, "_col"}, {2'b00, col}, 4'd0);
    check_output({tag, "_key_valid"}, {3'b000, key_valid}, 4'd0);
    check_output({tag, "_key_held"}, {3'b000, key_held}, 4'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    run_cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    int start;
    int k;
    int r1, c1, r2, c2;
    release_all();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    $display("[TB] idle scan");
    start = n_pulse;
    run_cycles(64);
    check_output("idle_pulses", 4'(n_pulse - start), 4'd0);

    $display("[TB] single key (2,1)");
    start = n_pulse;
    apply_stimulus(2, 1, 1'b1);
    wait_pulse("k21_pulse", LAT);
    run_cycles(20);
    check_output("k21_count", 4'(n_pulse - start), 4'd1);
    check_output("k21_row", {2'b00, last_row}, 4'd2);
    check_output("k21_col", {2'b00, last_col}, 4'd1);
    check_output("k21_held", {3'b000, key_held}, 4'd1);
    apply_stimulus(2, 1, 1'b0);
    wait_release("k21_release", 2 + DC * SD + 4);
    run_cycles(8);

    $display("[TB] bouncing key (3,3)");
    start = n_pulse;
    for (int b = 0; b < 3; b++) begin
      apply_stimulus(3, 3, 1'b1);
      run_cycles(SD);
      apply_stimulus(3, 3, 1'b0);
      run_cycles(SD);
    end
    apply_stimulus(3, 3, 1'b1);
    wait_pulse("k33_pulse", LAT + 6 * SD);
    run_cycles(20);
    check_output("k33_count", 4'(n_pulse - start), 4'd1);
    check_output("k33_row", {2'b00, last_row}, 4'd3);
    check_output("k33_col", {2'b00, last_col}, 4'd3);
    apply_stimulus(3, 3, 1'b0);
    wait_release("k33_release", 2 + DC * SD + 4);
    run_cycles(8);

    $display("[TB] two keys in column 0");
    start = n_pulse;
    apply_stimulus(1, 0, 1'b1);
    apply_stimulus(3, 0, 1'b1);
    wait_pulse("k10_pulse", LAT);
    check_output("k10_row", {2'b00, last_row}, 4'd1);
    check_output("k10_col", {2'b00, last_col}, 4'd0);
    apply_stimulus(1, 0, 1'b0);
    run_cycles(40);
    check_output("k10_count", 4'(n_pulse - start), 4'd1);
    check_output("k10_held", {3'b000, key_held}, 4'd1);
    apply_stimulus(3, 0, 1'b0);
    wait_release("k30_release", 2 + DC * SD + 4);
    run_cycles(8);

    $display("[TB] release glitch while held");
    start = n_pulse;
    apply_stimulus(0, 2, 1'b1);
    wait_pulse("k02_pulse", LAT);
    run_cycles(6);
    apply_stimulus(0, 2, 1'b0);
    run_cycles(SD);
    apply_stimulus(0, 2, 1'b1);
    run_cycles(30);
    check_output("glitch_held", {3'b000, key_held}, 4'd1);
    check_output("glitch_count", 4'(n_pulse - start), 4'd1);
    apply_stimulus(0, 2, 1'b0);
    wait_release("k02_release", 2 + DC * SD + 4);
    run_cycles(8);

    $display("[TB] reset during debounce and held");
    apply_stimulus(1, 2, 1'b1);
    k = 0;
    while ((m_mode != M_DEB) && (k < LAT)) begin
      run_cycles(1);
      k++;
    end
    check_output("reach_debounce", 4'(m_mode), 4'(M_DEB));
    pulse_reset("rst_deb");
    wait_pulse("rst_deb_pulse", LAT);
    run_cycles(10);
    check_output("rst_held_before", {3'b000, key_held}, 4'd1);
    pulse_reset("rst_held");
    wait_pulse("rst_held_pulse", LAT);
    check_output("rst_held_row", {2'b00, last_row}, 4'd1);
    check_output("rst_held_col", {2'b00, last_col}, 4'd2);
    apply_stimulus(1, 2, 1'b0);
    wait_release("k12_release", 2 + DC * SD + 4);
    run_cycles(8);

    $display("[TB] random key traffic");
    for (int it = 0; it < 30; it++) begin
      r1 = int'($urandom_range(0, 3));
      c1 = int'($urandom_range(0, 3));
      apply_stimulus(r1, c1, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        r2 = int'($urandom_range(0, 3));
        c2 = int'($urandom_range(0, 3));
        apply_stimulus(r2, c2, 1'b1);
      end
      run_cycles(int'($urandom_range(1, 40)));
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus(r1, c1, 1'b0);
        run_cycles(int'($urandom_range(1, 8)));
        apply_stimulus(r1, c1, 1'b1);
        run_cycles(int'($urandom_range(10, 40)));
      end
      release_all();
      run_cycles(int'($urandom_range(5, 50)));
    end
    release_all();
    run_cycles(60);
    check_output("final_held", {3'b000, key_held}, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
